// File: rtl/lbist_pkg.sv
// Shared logic-BIST definitions: PRPG LFSR geometry, default seed and controller states.
// Optional reseeding is selected per build with PRPG_RESEED_EN (see prpg_lfsr_ctrl).
package lbist_pkg;

    localparam int LFSR_W = 36;
    localparam int TAP_HI = 35;
    localparam int TAP_LO = 24;

    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 36'h000000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // An all-zero state would lock the LFSR, so zero seeds are replaced.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s,
                                                   input logic [LFSR_W-1:0] dflt);
        return (s == '0) ? dflt : s;
    endfunction

endpackage

// File: rtl/prpg_lfsr36.sv
// 36-bit Fibonacci LFSR, x^36+x^11+1: q[0] <= q[35]^q[24], remaining bits shift up.
// Load has priority over step; the state changes one cycle after the qualifying edge.
module prpg_lfsr36
    import lbist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RST_VAL = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (step) begin
            q_d = {q_q[LFSR_W-2:0], q_q[TAP_HI] ^ q_q[TAP_LO]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/prpg_lfsr_ctrl.sv
// PRPG controller: seeds the LFSR, steps it once per adv in RUN, counts patterns to NUM_PATTERNS.
// All outputs registered; PRPG_RESEED_EN adds periodic reseeding from reseed_seed.
module prpg_lfsr_ctrl
    import lbist_pkg::*;
#(
    parameter int                NUM_PATTERNS = 1024,
    parameter int                CNT_W        = 16,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_SEED_DEFAULT
`ifdef PRPG_RESEED_EN
    ,
    parameter int                RESEED_INTERVAL = 256
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              start,
    input  logic              adv,
`ifdef PRPG_RESEED_EN
    input  logic [LFSR_W-1:0] reseed_seed,
    output logic              reseed_pulse,
`endif
    output logic [LFSR_W-1:0] q,
    output logic              pattern_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pat_cnt
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               lfsr_load, lfsr_step;
    logic [LFSR_W-1:0]  lfsr_val;
`ifdef PRPG_RESEED_EN
    logic               reseed_pulse_q, reseed_pulse_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cnt_inc   = cnt_q + 1'b1;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        lfsr_val  = seed_fix(seed, SEED_DEFAULT);
`ifdef PRPG_RESEED_EN
        reseed_pulse_d = 1'b0;
`endif
        case (state_q)
            IDLE, DONE: begin
                // A seed loaded together with start becomes pattern 0 of the new run.
                lfsr_load = seed_load;
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (seed_load) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (adv) begin
                    cnt_d     = cnt_inc;
                    lfsr_step = 1'b1;
                    if (cnt_inc == CNT_W'(NUM_PATTERNS)) begin
                        state_d = DONE;
                    end
`ifdef PRPG_RESEED_EN
                    else if ((cnt_inc % CNT_W'(RESEED_INTERVAL)) == '0) begin
                        lfsr_load      = 1'b1;
                        lfsr_val       = seed_fix(reseed_seed, SEED_DEFAULT);
                        reseed_pulse_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef PRPG_RESEED_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reseed_pulse_q <= 1'b0;
        end else begin
            reseed_pulse_q <= reseed_pulse_d;
        end
    end

    assign reseed_pulse = reseed_pulse_q;
`endif

    prpg_lfsr36 #(
        .RST_VAL (SEED_DEFAULT)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (lfsr_val),
        .step     (lfsr_step),
        .q        (q)
    );

    assign pattern_valid = busy_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pat_cnt       = cnt_q;

endmodule
